vga_timing: RTL and testbench

Parametrised VGA timing generator. Produces h/v pixel counters, sync pulses, active-video and line/frame strobes from a single clock gated by a pixel clock-enable, so pixel rate is set by `CE` rather than a fabric-divided clock. Sits between the pixel-clock PLL and the draw/pixel pipeline in the VGA top level. A configurable output delay re-aligns syncs with a multi-stage draw pipeline.

---
 rtl/vga_timing_if.sv | 22 ++
 rtl/vga_timing.sv | 156 +++++++++++++++
 tb/tb_vga_timing.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - VGA timing output bundle: counters, syncs, strobes and frame count.
interface vga_timing_if #(
  parameter int CW = 13
) ();
  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          HSYNC;
  logic          VSYNC;
  logic          ACTIVE;
  logic          LINE_START;
  logic          FRAME_START;
  logic [7:0]    FRAME_COUNT;
  logic          BORDER;

  modport master (
    output h, v, HSYNC, VSYNC, ACTIVE, LINE_START, FRAME_START, FRAME_COUNT, BORDER
  );

  modport slave (
    input  h, v, HSYNC, VSYNC, ACTIVE, LINE_START, FRAME_START, FRAME_COUNT, BORDER
  );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - CE-qualified VGA timing generator with optional flag delay line.
// Optional outermost-pixel BORDER flag is built when VGA_TIMING_BORDER_EN is defined.
module vga_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 13,
  parameter int DELAY    = 0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CE,
  vga_timing_if.master    vid
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Flag vector layout shared by the decode register and every delay stage.
  localparam int F_HS  = 5;
  localparam int F_VS  = 4;
  localparam int F_ACT = 3;
  localparam int F_LS  = 2;
  localparam int F_FS  = 1;
  localparam int F_BD  = 0;
  localparam logic [5:0] FLAG_IDLE = {~H_POL, ~V_POL, 4'b0000};

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic [5:0]    flags_q, flags_d;
  logic [5:0]    flags_out;

  logic          hs_on, vs_on, active, line_start, frame_start, border;

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    frame_count_d = frame_count_q;
    if (CE) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d           = '0;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Decoding the next count lets the registered flags line up with h/v.
  always_comb begin
    hs_on       = (h_d >= CW'(HS_START)) && (h_d < CW'(HS_END));
    vs_on       = (v_d >= CW'(VS_START)) && (v_d < CW'(VS_END));
    active      = (h_d < CW'(H_ACTIVE)) && (v_d < CW'(V_ACTIVE));
    line_start  = (h_d == '0);
    frame_start = (h_d == '0) && (v_d == '0);
`ifdef VGA_TIMING_BORDER_EN
    border      = active && ((h_d == '0) || (h_d == CW'(H_ACTIVE - 1)) ||
                             (v_d == '0) || (v_d == CW'(V_ACTIVE - 1)));
`else
    border      = 1'b0;
`endif
  end

  always_comb begin
    flags_d = flags_q;
    if (CE) begin
      flags_d[F_HS]  = hs_on ? H_POL : ~H_POL;
      flags_d[F_VS]  = vs_on ? V_POL : ~V_POL;
      flags_d[F_ACT] = active;
      flags_d[F_LS]  = line_start;
      flags_d[F_FS]  = frame_start;
      flags_d[F_BD]  = border;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      frame_count_q <= '0;
      flags_q       <= FLAG_IDLE;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_count_q <= frame_count_d;
      flags_q       <= flags_d;
    end
  end

  generate
    if (DELAY == 0) begin : g_no_delay
      assign flags_out = flags_q;
    end else begin : g_delay
      logic [5:0] pipe_q [DELAY];
      logic [5:0] pipe_d [DELAY];

      always_comb begin
        for (int i = 0; i < DELAY; i++) begin
          pipe_d[i] = pipe_q[i];
        end
        if (CE) begin
          pipe_d[0] = flags_q;
          for (int i = 1; i < DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
          end
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < DELAY; i++) begin
            pipe_q[i] <= FLAG_IDLE;
          end
        end else begin
          for (int i = 0; i < DELAY; i++) begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign flags_out = pipe_q[DELAY-1];
    end
  endgenerate

  // Counters and frame count are never delayed; only the flag vector is.
  assign vid.h           = h_q;
  assign vid.v           = v_q;
  assign vid.FRAME_COUNT = frame_count_q;
  assign vid.HSYNC       = flags_out[F_HS];
  assign vid.VSYNC       = flags_out[F_VS];
  assign vid.ACTIVE      = flags_out[F_ACT];
  assign vid.LINE_START  = flags_out[F_LS];
  assign vid.FRAME_START = flags_out[F_FS];
  assign vid.BORDER      = flags_out[F_BD];

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - Directed bench for vga_timing: small mode, DELAY=3 and default 1024x768 timing.
module tb_vga_timing;

  logic CLK;
  logic RST_N;
  logic CE;

  int tests;
  int fails;
  int pix;

  vga_timing_if #(.CW(13)) vid0 ();
  vga_timing_if #(.CW(13)) vid3 ();
  vga_timing_if #(.CW(13)) vidd ();

  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(13), .DELAY(0)
  ) dut0 (.CLK(CLK), .RST_N(RST_N), .CE(CE), .vid(vid0));

  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(13), .DELAY(3)
  ) dut3 (.CLK(CLK), .RST_N(RST_N), .CE(CE), .vid(vid3));

  vga_timing dutd (.CLK(CLK), .RST_N(RST_N), .CE(CE), .vid(vidd));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Small mode: 8 pixels x 6 lines, hsync low at h=5,6, vsync low at v=4.
  function automatic int exp_h(input int n);
    return (n < 0) ? 7 : n % 8;
  endfunction

  function automatic int exp_v(input int n);
    return (n < 0) ? 5 : (n / 8) % 6;
  endfunction

  function automatic int exp_fc(input int n);
    return (n < 0) ? 0 : (n / 48 + 1) % 256;
  endfunction

  // {HSYNC, VSYNC, ACTIVE, LINE_START, FRAME_START, BORDER}
  function automatic logic [5:0] exp_flags(input int n);
    int   hh;
    int   vv;
    logic act;
    logic b;
    if (n < 0) return 6'b110000;
    hh  = n % 8;
    vv  = (n / 8) % 6;
    act = (hh < 4) && (vv < 3);
`ifdef VGA_TIMING_BORDER_EN
    b = act && (hh == 0 || hh == 3 || vv == 0 || vv == 2);
`else
    b = 1'b0;
`endif
    return {!(hh == 5 || hh == 6), !(vv == 4), act, hh == 0, (hh == 0) && (vv == 0), b};
  endfunction

  task automatic step(input logic ce);
    CE = ce;
    @(posedge CLK);
    #1;
    if (ce) pix++;
  endtask

  task automatic do_reset();
    CE    = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    pix   = -1;
  endtask

  task automatic test_reset();
    logic [5:0] f0;
    logic [5:0] f3;
    RST_N = 1'b1;
    CE    = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    f0 = {vid0.HSYNC, vid0.VSYNC, vid0.ACTIVE, vid0.LINE_START, vid0.FRAME_START, vid0.BORDER};
    f3 = {vid3.HSYNC, vid3.VSYNC, vid3.ACTIVE, vid3.LINE_START, vid3.FRAME_START, vid3.BORDER};
    tests++;
    if (vid0.h !== 13'd7 || vid0.v !== 13'd5) begin
      fails++;
      $display("FAIL reset_hv: got h=%0d v=%0d want h=7 v=5", vid0.h, vid0.v);
    end
    tests++;
    if (vid0.FRAME_COUNT !== 8'd0) begin
      fails++;
      $display("FAIL reset_fc: got %0d want 0", vid0.FRAME_COUNT);
    end
    tests++;
    if (f0 !== 6'b110000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 110000", f0);
    end
    tests++;
    if (f3 !== 6'b110000) begin
      fails++;
      $display("FAIL reset_flags_d3: got %b want 110000", f3);
    end
    tests++;
    if (vidd.h !== 13'd1343 || vidd.v !== 13'd805) begin
      fails++;
      $display("FAIL reset_default_hv: got h=%0d v=%0d want h=1343 v=805", vidd.h, vidd.v);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    pix   = -1;
  endtask

  task automatic test_ce_full();
    logic [5:0] f0;
    for (int k = 0; k < 96; k++) begin
      step(1'b1);
      f0 = {vid0.HSYNC, vid0.VSYNC, vid0.ACTIVE, vid0.LINE_START, vid0.FRAME_START, vid0.BORDER};
      tests++;
      if (vid0.h !== 13'(exp_h(pix)) || vid0.v !== 13'(exp_v(pix))) begin
        fails++;
        $display("FAIL ce_full_hv: pix=%0d got h=%0d v=%0d want h=%0d v=%0d",
                 pix, vid0.h, vid0.v, exp_h(pix), exp_v(pix));
      end
      tests++;
      if (f0 !== exp_flags(pix)) begin
        fails++;
        $display("FAIL ce_full_flags: pix=%0d got %b want %b", pix, f0, exp_flags(pix));
      end
      tests++;
      if (vid0.FRAME_COUNT !== 8'(exp_fc(pix))) begin
        fails++;
        $display("FAIL ce_full_fc: pix=%0d got %0d want %0d", pix, vid0.FRAME_COUNT, exp_fc(pix));
      end
    end
  endtask

  task automatic test_ce_third();
    logic [5:0] f0;
    do_reset();
    for (int k = 0; k < 48; k++) begin
      for (int c = 0; c < 3; c++) begin
        step(c == 0);
        f0 = {vid0.HSYNC, vid0.VSYNC, vid0.ACTIVE, vid0.LINE_START, vid0.FRAME_START, vid0.BORDER};
        tests++;
        if (vid0.h !== 13'(exp_h(pix)) || vid0.v !== 13'(exp_v(pix)) ||
            vid0.FRAME_COUNT !== 8'(exp_fc(pix))) begin
          fails++;
          $display("FAIL ce_third_count: pix=%0d phase=%0d got h=%0d v=%0d fc=%0d want h=%0d v=%0d fc=%0d",
                   pix, c, vid0.h, vid0.v, vid0.FRAME_COUNT, exp_h(pix), exp_v(pix), exp_fc(pix));
        end
        tests++;
        if (f0 !== exp_flags(pix)) begin
          fails++;
          $display("FAIL ce_third_flags: pix=%0d phase=%0d got %b want %b", pix, c, f0, exp_flags(pix));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] f0;
    logic [5:0] f3;
    int guard;
    guard = 0;
    while (!(exp_h(pix) == 2 && exp_v(pix) == 1) && guard < 100) begin
      step(1'b1);
      guard++;
    end
    tests++;
    if (vid0.h !== 13'd2 || vid0.v !== 13'd1) begin
      fails++;
      $display("FAIL mid_reset_pre: got h=%0d v=%0d want h=2 v=1", vid0.h, vid0.v);
    end
    CE    = 1'b0;
    RST_N = 1'b0;
    #1;
    f0 = {vid0.HSYNC, vid0.VSYNC, vid0.ACTIVE, vid0.LINE_START, vid0.FRAME_START, vid0.BORDER};
    f3 = {vid3.HSYNC, vid3.VSYNC, vid3.ACTIVE, vid3.LINE_START, vid3.FRAME_START, vid3.BORDER};
    tests++;
    if (vid0.h !== 13'd7 || vid0.v !== 13'd5 || vid0.FRAME_COUNT !== 8'd0 || f0 !== 6'b110000) begin
      fails++;
      $display("FAIL mid_reset_async: got h=%0d v=%0d fc=%0d flags=%b want h=7 v=5 fc=0 flags=110000",
               vid0.h, vid0.v, vid0.FRAME_COUNT, f0);
    end
    tests++;
    if (f3 !== 6'b110000) begin
      fails++;
      $display("FAIL mid_reset_d3: got flags=%b want 110000", f3);
    end
    CE = 1'b1;
    @(posedge CLK);
    #1;
    tests++;
    if (vid0.h !== 13'd7 || vid0.v !== 13'd5) begin
      fails++;
      $display("FAIL mid_reset_hold: got h=%0d v=%0d want h=7 v=5", vid0.h, vid0.v);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    pix   = -1;
    step(1'b1);
    f0 = {vid0.HSYNC, vid0.VSYNC, vid0.ACTIVE, vid0.LINE_START, vid0.FRAME_START, vid0.BORDER};
    tests++;
    if (vid0.h !== 13'd0 || vid0.v !== 13'd0 || vid0.FRAME_COUNT !== 8'd1 || f0[1] !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_first: got h=%0d v=%0d fc=%0d fs=%b want h=0 v=0 fc=1 fs=1",
               vid0.h, vid0.v, vid0.FRAME_COUNT, f0[1]);
    end
  endtask

  task automatic test_delay();
    logic [5:0] f3;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      step(1'b1);
      f3 = {vid3.HSYNC, vid3.VSYNC, vid3.ACTIVE, vid3.LINE_START, vid3.FRAME_START, vid3.BORDER};
      tests++;
      if (vid3.h !== 13'(exp_h(pix)) || vid3.v !== 13'(exp_v(pix))) begin
        fails++;
        $display("FAIL delay_hv: pix=%0d got h=%0d v=%0d want h=%0d v=%0d",
                 pix, vid3.h, vid3.v, exp_h(pix), exp_v(pix));
      end
      tests++;
      if (f3 !== exp_flags(pix - 3)) begin
        fails++;
        $display("FAIL delay_flags: pix=%0d got %b want %b", pix, f3, exp_flags(pix - 3));
      end
    end
  endtask

  task automatic test_frame_wrap();
    do_reset();
    for (int n = 0; n <= 255 * 48; n++) begin
      step(1'b1);
      if (n == 47 || n == 48 || n == 255 * 48 - 1 || n == 255 * 48) begin
        tests++;
        if (vid0.FRAME_COUNT !== 8'(exp_fc(n)) || vid0.FRAME_START !== (n % 48 == 0)) begin
          fails++;
          $display("FAIL frame_wrap: n=%0d got fc=%0d fs=%b want fc=%0d fs=%b",
                   n, vid0.FRAME_COUNT, vid0.FRAME_START, exp_fc(n), (n % 48 == 0));
        end
      end
    end
  endtask

  task automatic test_border();
    int   pts [7];
    logic want [7];
    pts = '{0, 3, 1, 16, 18, 9, 4};
`ifdef VGA_TIMING_BORDER_EN
    want = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    want = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    for (int n = 0; n <= 18; n++) begin
      step(1'b1);
      for (int i = 0; i < 7; i++) begin
        if (pts[i] == n) begin
          tests++;
          if (vid0.BORDER !== want[i]) begin
            fails++;
            $display("FAIL border: h=%0d v=%0d got %b want %b", n % 8, n / 8, vid0.BORDER, want[i]);
          end
        end
      end
    end
  endtask

  task automatic test_default_line();
    int   hh;
    logic want_hs;
    logic want_act;
    do_reset();
    for (int n = 0; n < 1346; n++) begin
      step(1'b1);
      hh       = n % 1344;
      want_hs  = !(hh >= 1048 && hh <= 1183);
      want_act = (hh < 1024);
      tests++;
      if (vidd.h !== 13'(hh) || vidd.v !== 13'(n / 1344) || vidd.HSYNC !== want_hs ||
          vidd.ACTIVE !== want_act || vidd.VSYNC !== 1'b1) begin
        fails++;
        $display("FAIL default_line: n=%0d got h=%0d v=%0d hs=%b act=%b vs=%b want h=%0d v=%0d hs=%b act=%b vs=1",
                 n, vidd.h, vidd.v, vidd.HSYNC, vidd.ACTIVE, vidd.VSYNC, hh, n / 1344, want_hs, want_act);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    pix   = -1;
    test_reset();
    test_ce_full();
    test_ce_third();
    test_mid_reset();
    test_delay();
    test_frame_wrap();
    test_border();
    test_default_line();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
